song_sequencer: RTL and testbench

Plays a fixed melody by driving the note-code and enable inputs of the downstream `music_notes` tone generator. It steps through a 16-entry internal song table of {note, duration} pairs, timing each note in beat ticks derived from the 100 MHz `clk`. It inserts a silent gap between notes, then stops or loops at the end-of-song marker. It sits between the board's button/switch logic (start, stop, loop) and the tone generator.

---
 rtl/song_sequencer_if.sv | 22 ++
 rtl/song_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Control/status bundle between the board's button logic and the song sequencer.
// The master side drives start/stop/loop; the sequencer returns note code, enable and status.
interface song_sequencer_if;
    logic       start;
    logic       stop;
    logic       loop;
    logic [3:0] v;
    logic       out;
    logic       busy;
    logic       done;
    logic [3:0] step;

    modport master (
        output start, stop, loop,
        input  v, out, busy, done, step
    );

    modport slave (
        input  start, stop, loop,
        output v, out, busy, done, step
    );
endinterface

// File: rtl/song_sequencer.sv
// Steps through a fixed 16-entry {note, duration} table, timing notes in beat ticks
// and inserting silent gaps; stops or loops at the end-of-song marker.
module song_sequencer #(
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic            clk,
    input  logic            reset,
    song_sequencer_if.slave bus
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [3:0]    v_q, v_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    dur_cnt_q, dur_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          wrap_q, wrap_d;

    logic [7:0]    entry;
    logic [3:0]    entry_note;
    logic [3:0]    entry_dur;
    logic          tick_wrap;

    // Song table: {note, dur}; dur = 0 marks the end of the song.
    always_comb begin
        entry = 8'h00;
        case (step_q)
            4'd0:    entry = 8'h12;
            4'd1:    entry = 8'h22;
            4'd2:    entry = 8'h32;
            4'd3:    entry = 8'h42;
            4'd4:    entry = 8'h52;
            4'd5:    entry = 8'h62;
            4'd6:    entry = 8'h72;
            4'd7:    entry = 8'h82;
            4'd8:    entry = 8'h84;
            4'd9:    entry = 8'h02;
            default: entry = 8'h00;
        endcase
    end

    assign entry_note = entry[7:4];
    assign entry_dur  = entry[3:0];
    assign tick_wrap  = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        v_d        = v_q;
        out_d      = out_q;
        done_d     = 1'b0;
        dur_cnt_d  = dur_cnt_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        wrap_d     = wrap_q;

        case (state_q)
            S_IDLE: begin
                v_d   = 4'd0;
                out_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    step_d  = 4'd0;
                    wrap_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Running off entry 15 counts as end of song just like a dur=0 marker.
                if (wrap_q || (entry_dur == 4'd0)) begin
                    wrap_d = 1'b0;
                    if (bus.loop) begin
                        step_d = 4'd0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    v_d        = entry_note;
                    out_d      = (entry_note != 4'd0);
                    dur_cnt_d  = entry_dur;
                    tick_cnt_d = '0;
                    state_d    = S_PLAY;
                end
            end

            S_PLAY: begin
                tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
                if (tick_wrap) begin
                    dur_cnt_d = dur_cnt_q - 4'd1;
                    if (dur_cnt_q == 4'd1) begin
                        v_d   = 4'd0;
                        out_d = 1'b0;
                        if (GAP_TICKS > 0) begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end else begin
                            step_d  = step_q + 4'd1;
                            wrap_d  = (step_q == 4'd15);
                            state_d = S_LOAD;
                        end
                    end
                end
            end

            S_GAP: begin
                tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
                if (tick_wrap) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        step_d  = step_q + 4'd1;
                        wrap_d  = (step_q == 4'd15);
                        state_d = S_LOAD;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided.
        if (bus.stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            step_d     = 4'd0;
            v_d        = 4'd0;
            out_d      = 1'b0;
            done_d     = 1'b0;
            dur_cnt_d  = 4'd0;
            tick_cnt_d = '0;
            gap_cnt_d  = '0;
            wrap_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= 4'd0;
            v_q        <= 4'd0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dur_cnt_q  <= 4'd0;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            v_q        <= v_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.v    = v_q;
    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus pushes the expected per-cycle outputs
// derived from the song rules; a negedge monitor pops and compares them.
module tb_song_sequencer;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;

    typedef struct packed {
        logic [3:0] v;
        logic       out;
        logic       busy;
        logic       done;
        logic [3:0] step;
    } snap_t;

    typedef struct packed {
        logic [31:0] cyc;
        snap_t       s;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc   = 32'd0;
    int          errors = 0;
    int          checks = 0;

    logic [3:0]  note_tab [16];
    logic [3:0]  dur_tab  [16];
    snap_t       tl [$];
    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [31:0] next_cyc;
    logic [3:0]  idle_step;

    song_sequencer_if bus_if ();

    song_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic snap_t mk_snap(input logic [3:0] v, input logic o, input logic b,
                                      input logic d, input logic [3:0] st);
        snap_t s;
        s.v    = v;
        s.out  = o;
        s.busy = b;
        s.done = d;
        s.step = st;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return mk_snap(bus_if.v, bus_if.out, bus_if.busy, bus_if.done, bus_if.step);
    endfunction

    task automatic check_snap(input string name, input snap_t want);
        snap_t got;
        got = dut_snap();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got v=%0d out=%0b busy=%0b done=%0b step=%0d required v=%0d out=%0b busy=%0b done=%0b step=%0d",
                     name, cyc, got.v, got.out, got.busy, got.done, got.step,
                     want.v, want.out, want.busy, want.done, want.step);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expectation cyc=%0d got no sample required sample at cyc=%0d", cyc, mon_e.cyc);
            end else begin
                check_snap("trace", mon_e.s);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] c, input snap_t s);
        exp_t e;
        e.cyc = c;
        e.s   = s;
        sb_q.push_back(e);
    endtask

    // Expected outputs for one or more back-to-back passes of the song, starting
    // with the LOAD cycle of entry 0 and ending with the end-marker LOAD cycle.
    task automatic build_tl(input int passes);
        tl.delete();
        for (int p = 0; p < passes; p++) begin
            int e;
            e = 0;
            while (e < 16 && dur_tab[e] != 4'd0) begin
                tl.push_back(mk_snap(4'd0, 1'b0, 1'b1, 1'b0, 4'(e)));
                for (int i = 0; i < int'(dur_tab[e]) * TICK_DIV; i++)
                    tl.push_back(mk_snap(note_tab[e], note_tab[e] != 4'd0, 1'b1, 1'b0, 4'(e)));
                for (int i = 0; i < GAP_TICKS * TICK_DIV; i++)
                    tl.push_back(mk_snap(4'd0, 1'b0, 1'b1, 1'b0, 4'(e)));
                e++;
            end
            tl.push_back(mk_snap(4'd0, 1'b0, 1'b1, 1'b0, 4'(e)));
        end
    endtask

    task automatic idle_for(input int m);
        for (int i = 0; i < m; i++)
            push_exp(next_cyc + 32'(i), mk_snap(4'd0, 1'b0, 1'b0, 1'b0, idle_step));
        next_cyc = next_cyc + 32'(m);
        while (cyc < next_cyc - 32'd1) tick();
    endtask

    // stop_at = 0 plays to the end; otherwise stop is sampled at edge start+stop_at.
    task automatic run_song(input int passes, input logic final_loop, input int stop_at);
        int          len, pass_len, last_j, j, rem, nexp;
        logic [31:0] n;
        build_tl(passes);
        len      = tl.size();
        pass_len = len / passes;
        n        = next_cyc;
        nexp     = (stop_at > 0) ? stop_at : len;
        for (int k = 0; k < nexp; k++) push_exp(n + 32'(k), tl[k]);
        if (stop_at == 0) begin
            push_exp(n + 32'(len), mk_snap(4'd0, 1'b0, 1'b0, 1'b1, tl[len-1].step));
            idle_step = tl[len-1].step;
            next_cyc  = n + 32'(len) + 32'd1;
            last_j    = len;
        end else begin
            idle_step = 4'd0;
            next_cyc  = n + 32'(stop_at);
            last_j    = stop_at;
        end
        $display("run start_cyc=%0d passes=%0d loop=%0b stop_at=%0d", n, passes, final_loop, stop_at);
        bus_if.loop  = 1'($urandom);
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        j = 1;
        while (j <= last_j) begin
            rem = j % pass_len;
            bus_if.loop  = (rem >= 1 && rem < 100) ? 1'($urandom) : final_loop;
            bus_if.start = ($urandom_range(0, 15) == 0);
            bus_if.stop  = (j == stop_at);
            tick();
            j++;
        end
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
    endtask

    initial begin
        logic [31:0] n;
        int          mode;

        for (int i = 0; i < 16; i++) begin
            note_tab[i] = 4'd0;
            dur_tab[i]  = 4'd0;
        end
        for (int i = 0; i < 8; i++) begin
            note_tab[i] = 4'(i + 1);
            dur_tab[i]  = 4'd2;
        end
        note_tab[8] = 4'd8; dur_tab[8] = 4'd4;
        note_tab[9] = 4'd0; dur_tab[9] = 4'd2;

        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.loop  = 1'b0;

        tick();
        tick();
        check_snap("reset_state", mk_snap(4'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        reset     = 1'b0;
        next_cyc  = cyc + 32'd1;
        idle_step = 4'd0;
        idle_for(3);

        // Full song, no loop: done one cycle after edge start+139.
        run_song(1, 1'b0, 0);
        idle_for(2);

        // Stop in the gap of entry 5, then replay on the very next cycle.
        run_song(1, 1'b0, 76);
        idle_for(1);
        run_song(1, 1'b0, 0);
        idle_for(2);

        // start and stop together while idle.
        $display("run start_cyc=%0d start+stop while idle", next_cyc);
        bus_if.start = 1'b1;
        bus_if.stop  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        idle_for(4);

        // Looping across the end marker, stopped during the second pass.
        run_song(2, 1'b1, 150);
        idle_for(2);

        // Asynchronous reset during PLAY of entry 3.
        build_tl(1);
        n = next_cyc;
        $display("run start_cyc=%0d async reset mid-note", n);
        for (int k = 0; k < 44; k++) push_exp(n + 32'(k), tl[k]);
        push_exp(n + 32'd44, mk_snap(4'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        push_exp(n + 32'd45, mk_snap(4'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        bus_if.loop  = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        while (cyc < n + 32'd44) tick();
        #2;
        reset = 1'b1;
        #1;
        check_snap("async_reset", mk_snap(4'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        tick();
        reset     = 1'b0;
        next_cyc  = n + 32'd46;
        idle_step = 4'd0;
        idle_for(6);

        for (int it = 0; it < 6; it++) begin
            mode = $urandom_range(0, 2);
            case (mode)
                0:       run_song(1, 1'b0, 0);
                1:       run_song(1, 1'b0, $urandom_range(1, 139));
                default: run_song(2, 1'b1, $urandom_range(140, 278));
            endcase
            idle_for($urandom_range(1, 4));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending required 0 pending", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
